// File: rtl/apb_dac_pkg.sv
// Shared definitions for the multi-channel APB DAC: register map, field positions,
// bus states and the FIFO entry layout.
package apb_dac_pkg;

   localparam logic [31:0] OFF_CTRL    = 32'h00;
   localparam logic [31:0] OFF_STATUS  = 32'h04;
   localparam logic [31:0] OFF_DIVIDER = 32'h08;
   localparam logic [31:0] OFF_FIFO    = 32'h0C;
   localparam logic [31:0] OFF_CH_BASE = 32'h10;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_WAIT_LSB  = 8;
   localparam int CTRL_WAIT_W    = 4;
   localparam int STAT_EMPTY_BIT = 8;
   localparam int STAT_FULL_BIT  = 9;
   localparam int STAT_OVF_BIT   = 10;
   localparam int FIFO_CH_LSB    = 24;
   localparam int FIFO_CH_W      = 4;
   localparam int CODE_W_MAX     = 24;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } apb_state_e;

   // Code field is sized for the widest supported resolution; narrower builds ignore the top bits.
   typedef struct packed {
      logic [FIFO_CH_W-1:0]  ch;
      logic [CODE_W_MAX-1:0] code;
   } fifo_entry_t;

endpackage

// File: rtl/dac_sample_fifo.sv
// Sample FIFO with registered count; push is refused when full and pop when empty,
// both judged on the pre-edge count.
module dac_sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 28
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: storage is deliberately left out of reset; an entry is never read before it is written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/apb_dac_mc.sv
// Multi-channel APB DAC slave: APB wait-state FSM, register decode, sample FIFO drained
// at a programmable rate into per-channel code registers, and real-valued outputs.
module apb_dac_mc
   import apb_dac_pkg::*;
#(
   parameter int  NUM_CH     = 4,
   parameter int  DATA_W     = 12,
   parameter int  FIFO_DEPTH = 8,
   parameter int  ADDR_W     = 8,
   parameter real VREF       = 3.3,
   parameter int  DIV_RST    = 16
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [ADDR_W-1:0]        PADDR,
   input  logic [31:0]              PWDATA,
   output logic [31:0]              PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic [NUM_CH*DATA_W-1:0] code_o,
   output real                      vout [NUM_CH],
   output logic                     ovf_irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = $bits(fifo_entry_t);

   apb_state_e               state_q, state_d;
   logic [CTRL_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                     ctrl_en_q;
   logic [CTRL_WAIT_W-1:0]   ctrl_wait_q;
   logic [15:0]              divider_q;
   logic                     ovf_q;
   logic [31:0]              prdata_q;
   logic [NUM_CH-1:0][DATA_W-1:0] code_q;
   logic [15:0]              period_q, period_d, div_eff;
   logic                     tick;

   logic [31:0]              addr, rdata_c;
   logic [DATA_W-1:0]        rd_code;
   logic                     is_ctrl, is_status, is_div, is_fifo, is_ch;
   logic                     ch_bad, rd_err, wr_err, err_c;
   logic                     setup_c, access_c, pready_c, wr_fire;
   fifo_entry_t              push_entry, head;
   logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]            fifo_count;
   logic                     unused_bits;

   assign addr      = 32'(PADDR);
   assign is_ctrl   = (addr == OFF_CTRL);
   assign is_status = (addr == OFF_STATUS);
   assign is_div    = (addr == OFF_DIVIDER);
   assign is_fifo   = (addr == OFF_FIFO);
   assign ch_bad    = 32'(PWDATA[FIFO_CH_LSB +: FIFO_CH_W]) >= 32'(NUM_CH);
   assign rd_err    = ~(is_ctrl | is_status | is_div | is_ch);
   assign wr_err    = ~(is_ctrl | is_status | is_div | is_fifo) | (is_fifo & (ch_bad | fifo_full));
   assign err_c     = PWRITE ? wr_err : rd_err;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      is_ch   = 1'b0;
      rd_code = '0;
      rdata_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr == OFF_CH_BASE + 32'(4 * i)) begin
            is_ch   = 1'b1;
            rd_code = code_q[i];
         end
      end
      if (is_ctrl) begin
         rdata_c[CTRL_EN_BIT]                   = ctrl_en_q;
         rdata_c[CTRL_WAIT_LSB +: CTRL_WAIT_W]  = ctrl_wait_q;
      end else if (is_status) begin
         rdata_c[CW-1:0]         = fifo_count;
         rdata_c[STAT_EMPTY_BIT] = fifo_empty;
         rdata_c[STAT_FULL_BIT]  = fifo_full;
         rdata_c[STAT_OVF_BIT]   = ovf_q;
      end else if (is_div) begin
         rdata_c[15:0] = divider_q;
      end else if (is_ch) begin
         rdata_c[DATA_W-1:0] = rd_code;
      end
   end

   // An access phase only counts after a setup phase seen by this slave.
   assign setup_c  = PSEL & ~PENABLE;
   assign access_c = PSEL & PENABLE & (state_q != S_IDLE);
   assign pready_c = access_c & (wait_cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      if (setup_c) begin
         state_d    = S_SETUP;
         wait_cnt_d = ctrl_wait_q;
      end else if (access_c) begin
         if (pready_c) begin
            state_d = S_IDLE;
         end else begin
            state_d    = S_ACCESS;
            wait_cnt_d = wait_cnt_q - CTRL_WAIT_W'(1);
         end
      end else begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign div_eff  = (divider_q == '0) ? 16'd1 : divider_q;
   assign tick     = ctrl_en_q & (period_q >= div_eff - 16'd1);
   assign period_d = (!ctrl_en_q || tick) ? 16'd0 : period_q + 16'd1;

   assign wr_fire         = pready_c & PWRITE & ~wr_err;
   assign fifo_push       = wr_fire & is_fifo;
   assign fifo_pop        = tick & ~fifo_empty;
   assign push_entry.ch   = PWDATA[FIFO_CH_LSB +: FIFO_CH_W];
   assign push_entry.code = CODE_W_MAX'(PWDATA[DATA_W-1:0]);

   dac_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ctrl_en_q   <= 1'b0;
         ctrl_wait_q <= '0;
         divider_q   <= 16'(DIV_RST);
         ovf_q       <= 1'b0;
         prdata_q    <= '0;
         code_q      <= '0;
         period_q    <= '0;
      end else begin
         period_q <= period_d;
         if (setup_c) prdata_q <= (!PWRITE && !rd_err) ? rdata_c : 32'd0;
         if (wr_fire && is_ctrl) begin
            ctrl_en_q   <= PWDATA[CTRL_EN_BIT];
            ctrl_wait_q <= PWDATA[CTRL_WAIT_LSB +: CTRL_WAIT_W];
         end
         if (wr_fire && is_div) divider_q <= PWDATA[15:0];
         // A rejected push into a full FIFO is the only error with a side effect.
         if (pready_c && PWRITE && is_fifo && fifo_full) ovf_q <= 1'b1;
         else if (wr_fire && is_status && PWDATA[STAT_OVF_BIT]) ovf_q <= 1'b0;
         if (fifo_pop) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (head.ch == FIFO_CH_W'(i)) code_q[i] <= head.code[DATA_W-1:0];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         vout[i] = real'(code_q[i]) * VREF / ((2.0 ** DATA_W) - 1.0);
      end
   end

   assign PRDATA      = prdata_q;
   assign PREADY      = pready_c;
   assign PSLVERR     = pready_c & err_c;
   assign code_o      = code_q;
   assign ovf_irq     = ovf_q;
   assign unused_bits = ^{PWDATA[31:28], PWDATA[23:16], head.code};

endmodule

// File: tb/tb_apb_dac_mc.sv
// Directed bench for apb_dac_mc: each APB transfer queues its expected response,
// which is popped and compared when the slave signals PREADY.
module tb_apb_dac_mc;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 12;

   logic        PCLK = 1'b0;
   logic        PRESET, PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR, ovf_irq;
   logic [NUM_CH*DATA_W-1:0] code_o;
   real         vout [NUM_CH];

   int checks = 0;
   int errors = 0;
   int m_wait = 0;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
      int          cycles;
   } exp_t;

   exp_t sb_q [$];

   always #5 PCLK = ~PCLK;

   apb_dac_mc #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (8),
      .ADDR_W     (8),
      .VREF       (3.3),
      .DIV_RST    (16)
   ) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .code_o  (code_o),
      .vout    (vout),
      .ovf_irq (ovf_irq)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_real(input string tag, input real obs, input real exp);
      checks++;
      assert ((obs - exp) < 1.0e-6 && (exp - obs) < 1.0e-6) else begin
         errors++;
         $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the bus idle or just finished; ends one negedge after PREADY.
   task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input string tag, input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      exp_t got;
      int   cyc = 1;
      e.tag    = tag;
      e.data   = exp_data;
      e.err    = exp_err;
      e.cycles = m_wait + 1;
      sb_q.push_back(e);
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      while (!PREADY && cyc < 20) begin
         @(negedge PCLK);
         #1;
         cyc++;
      end
      got = sb_q.pop_front();
      check({got.tag, ".ready"},  64'(PREADY),  64'(1));
      check({got.tag, ".cycles"}, 64'(cyc),     64'(got.cycles));
      check({got.tag, ".data"},   64'(PRDATA),  64'(got.data));
      check({got.tag, ".err"},    64'(PSLVERR), 64'(got.err));
      if (wr && !exp_err && addr == 8'h00) m_wait = int'(wdata[11:8]);
      @(negedge PCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET  = 1'b1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;

      check("rst.pready",  64'(PREADY),  64'(0));
      check("rst.pslverr", 64'(PSLVERR), 64'(0));
      check("rst.prdata",  64'(PRDATA),  64'(0));
      check("rst.code",    64'(code_o),  64'(0));
      check("rst.ovf_irq", 64'(ovf_irq), 64'(0));
      for (int i = 0; i < NUM_CH; i++) check_real($sformatf("rst.vout%0d", i), vout[i], 0.0);

      apb(1'b0, 8'h08, 32'h0, "rd_div_rst",  32'd16,    1'b0);
      apb(1'b0, 8'h04, 32'h0, "rd_stat_rst", 32'h100,   1'b0);

      // Single sample through the FIFO to channel 2 at full scale.
      apb(1'b1, 8'h00, 32'h1,        "wr_ctrl_en",  32'h0, 1'b0);
      apb(1'b1, 8'h08, 32'd4,        "wr_div4",     32'h0, 1'b0);
      apb(1'b1, 8'h0C, 32'h02000FFF, "push_ch2",    32'h0, 1'b0);
      for (int k = 0; k < 20 && code_o[2*DATA_W +: DATA_W] != 12'hFFF; k++) @(negedge PCLK);
      check("drain.code", 64'(code_o), 64'h0000_000F_FF00_0000);
      check_real("drain.vout2", vout[2], 3.3);
      apb(1'b0, 8'h18, 32'h0, "rd_ch2",   32'hFFF, 1'b0);
      apb(1'b0, 8'h00, 32'h0, "rd_ctrl",  32'h1,   1'b0);

      // Wait states.
      apb(1'b1, 8'h00, 32'h301, "wr_ctrl_wait3", 32'h0,   1'b0);
      apb(1'b0, 8'h04, 32'h0,   "rd_stat_wait3", 32'h100, 1'b0);
      apb(1'b1, 8'h00, 32'h000, "wr_ctrl_off",   32'h0,   1'b0);

      // Decode and argument errors leave state untouched.
      apb(1'b1, 8'h0C, 32'h05000123, "push_badch", 32'h0,   1'b1);
      apb(1'b1, 8'h10, 32'h55,       "wr_ro_ch0",  32'h0,   1'b1);
      apb(1'b0, 8'h0C, 32'h0,        "rd_fifo",    32'h0,   1'b1);
      apb(1'b0, 8'h20, 32'h0,        "rd_unmap",   32'h0,   1'b1);
      apb(1'b0, 8'h04, 32'h0,        "rd_stat_err",32'h100, 1'b1 ^ 1'b1);
      check("err.code", 64'(code_o), 64'h0000_000F_FF00_0000);

      // Fill the FIFO with the drain disabled, then overflow it.
      for (int k = 1; k <= 8; k++)
         apb(1'b1, 8'h0C, (32'((k - 1) % 4) << 24) | 32'(k), $sformatf("push%0d", k), 32'h0, 1'b0);
      apb(1'b1, 8'h0C, 32'h00000009, "push9_full", 32'h0,   1'b1);
      apb(1'b0, 8'h04, 32'h0,        "rd_stat_ovf", 32'h608, 1'b0);
      check("ovf.irq_set", 64'(ovf_irq), 64'(1));
      apb(1'b1, 8'h04, 32'h400,      "w1c_ovf",     32'h0,   1'b0);
      apb(1'b0, 8'h04, 32'h0,        "rd_stat_clr", 32'h208, 1'b0);
      check("ovf.irq_clr", 64'(ovf_irq), 64'(0));

      // Push while full lands on the same edge as a pop: rejected, and count only drops.
      apb(1'b1, 8'h08, 32'd2,        "wr_div2",      32'h0,   1'b0);
      apb(1'b1, 8'h00, 32'h1,        "wr_ctrl_en2",  32'h0,   1'b0);
      apb(1'b1, 8'h0C, 32'h03000AAA, "push_at_pop",  32'h0,   1'b1);
      apb(1'b1, 8'h00, 32'h0,        "wr_ctrl_dis",  32'h0,   1'b0);
      apb(1'b0, 8'h04, 32'h0,        "rd_stat_pp",   32'h406, 1'b0);
      check("pp.code",    64'(code_o),  64'h0000_000F_FF00_2001);
      check("pp.ovf_irq", 64'(ovf_irq), 64'(1));

      // Drain the rest one entry per cycle across the pointer wrap.
      apb(1'b1, 8'h08, 32'd1, "wr_div1",     32'h0, 1'b0);
      apb(1'b1, 8'h00, 32'h1, "wr_ctrl_en3", 32'h0, 1'b0);
      repeat (12) @(negedge PCLK);
      check("final.code", 64'(code_o), 64'h0000_0080_0700_6005);
      check_real("final.vout3", vout[3], 8.0 * 3.3 / 4095.0);
      apb(1'b0, 8'h04, 32'h0, "rd_stat_final", 32'h500, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
